vector_demux_reg: RTL

Registered one-to-N vector demultiplexer with valid/ready handshakes. It is the distribution-side counterpart of the vectorized mux. It accepts one BIT_WIDTH vector per cycle and steers it, by a select index, into one of NUM_VECTORS single-entry output registers. Each output register drains independently. Used between dispatch and per-unit queues/reservation stations, and includes a synchronous flush for pipeline squash.

---
 rtl/vector_demux_reg.sv | 63 ++++++
 1 files changed

// File: rtl/vector_demux_reg.sv
// Registered one-to-N vector demultiplexer: steers each accepted input vector into
// one of NUM_VECTORS single-entry holding registers, each drained by its own valid/ready.
module vector_demux_reg #(
    parameter  int BIT_WIDTH   = 8,
    parameter  int NUM_VECTORS = 4,
    localparam int SEL_W       = $clog2(NUM_VECTORS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic [BIT_WIDTH-1:0]               in_data,
    input  logic [SEL_W-1:0]                   in_sel,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [NUM_VECTORS*BIT_WIDTH-1:0]   out_data,
    output logic [NUM_VECTORS-1:0]             out_valid,
    input  logic [NUM_VECTORS-1:0]             out_ready,
    output logic                               busy
);

    logic [NUM_VECTORS-1:0][BIT_WIDTH-1:0] r_data;
    logic [NUM_VECTORS-1:0]                r_valid;

    logic                   w_in_ready;
    logic                   w_accept;
    logic [NUM_VECTORS-1:0] w_load;
    logic [NUM_VECTORS-1:0] w_drain;

    // A port can take a new vector when empty or when its current vector leaves this cycle.
    assign w_in_ready = ~flush & (~r_valid[in_sel] | out_ready[in_sel]);
    assign w_accept   = in_valid & w_in_ready;
    assign w_drain    = r_valid & out_ready;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            w_load[i] = w_accept && (in_sel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_VECTORS; g++) begin : g_port
        // Flush beats load beats drain; a load in the same cycle as a drain keeps the port full.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data[g]  <= '0;
                r_valid[g] <= 1'b0;
            end else if (flush) begin
                r_valid[g] <= 1'b0;
            end else if (w_load[g]) begin
                r_data[g]  <= in_data;
                r_valid[g] <= 1'b1;
            end else if (w_drain[g]) begin
                r_valid[g] <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = |r_valid;

endmodule
